// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with a binary-encoded grant, intended to drive a downstream
// index-to-one-hot decoder. Grants are held until release_i or an optional hold timeout.
module rr_grant_encoder #(
    parameter int ENCODE_WIDTH = 1,
    parameter int HOLD_MAX     = 0,
    localparam int DECODE_WIDTH = 1 << ENCODE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DECODE_WIDTH-1:0] req,
    input  logic                    release_i,
    output logic [ENCODE_WIDTH-1:0] grant_idx,
    output logic                    grant_valid,
    output logic                    timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
    localparam logic [7:0] HOLD_LAST  = 8'(HOLD_MAX - 1);

    state_t                  state_q, state_d;
    logic [ENCODE_WIDTH-1:0] ptr_q, ptr_d;
    logic [ENCODE_WIDTH-1:0] idx_d;
    logic                    valid_d;
    logic                    timeout_d;
    logic [7:0]              hold_cnt_q, hold_cnt_d;
    logic [ENCODE_WIDTH-1:0] arb_base;
    logic [ENCODE_WIDTH-1:0] winner;
    logic                    hold_expired;
    logic                    grant_end;

    // Scan downward so the last hit, i.e. the one closest to base, wins.
    function automatic logic [ENCODE_WIDTH-1:0] pick(
        input logic [ENCODE_WIDTH-1:0] base,
        input logic [DECODE_WIDTH-1:0] r
    );
        logic [ENCODE_WIDTH-1:0] cand;
        pick = base;
        for (int i = DECODE_WIDTH - 1; i >= 0; i--) begin
            cand = base + ENCODE_WIDTH'(i);
            if (r[cand]) pick = cand;
        end
    endfunction

    // A grant ending this edge re-arbitrates from the rotated pointer, not the stale one.
    assign arb_base     = (state_q == GRANT) ? grant_idx + ENCODE_WIDTH'(1) : ptr_q;
    assign winner       = pick(arb_base, req);
    assign hold_expired = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
    assign grant_end    = release_i || hold_expired;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        state_d    = state_q;
        ptr_d      = ptr_q;
        idx_d      = grant_idx;
        valid_d    = grant_valid;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    idx_d      = winner;
                    valid_d    = 1'b1;
                    hold_cnt_d = 8'd0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                if (grant_end) begin
                    ptr_d     = grant_idx + ENCODE_WIDTH'(1);
                    timeout_d = hold_expired && !release_i;
                    if (|req) begin
                        idx_d      = winner;
                        hold_cnt_d = 8'd0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end else if (hold_cnt_q != 8'hFF) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
            hold_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_idx   <= idx_d;
            grant_valid <= valid_d;
            timeout     <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: two instances (no timeout, HOLD_MAX=4) share stimulus;
// a cycle-level reference model feeds per-instance scoreboards checked by a monitor.
module tb_rr_grant_encoder;

    localparam int EW = 2;
    localparam int N  = 4;

    typedef struct {
        bit valid;
        int idx;
        bit idx_care;
        bit tmo;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          rel;
    logic [EW-1:0] idx0, idx1;
    logic          v0, v1, t0, t1;
    logic [N-1:0]  sel0, sel1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: owner -1 means no grant; held counts cycles the grant has been visible.
    int owner[2];
    int ptr[2];
    int held[2];
    int last_idx[2];
    int hold_max[2] = '{0, 4};

    exp_t sb0[$];
    exp_t sb1[$];

    always #5 clk = ~clk;

    rr_grant_encoder #(.ENCODE_WIDTH(EW), .HOLD_MAX(0)) u_dut0 (
        .clk(clk), .rst(rst), .req(req), .release_i(rel),
        .grant_idx(idx0), .grant_valid(v0), .timeout(t0)
    );

    rr_grant_encoder #(.ENCODE_WIDTH(EW), .HOLD_MAX(4)) u_dut1 (
        .clk(clk), .rst(rst), .req(req), .release_i(rel),
        .grant_idx(idx1), .grant_valid(v1), .timeout(t1)
    );

    // Stand-in for the downstream decoder fed by grant_idx.
    assign sel0 = N'(1) << idx0;
    assign sel1 = N'(1) << idx1;

    function automatic int pick(int base, logic [N-1:0] q);
        for (int i = 0; i < N; i++) begin
            if (q[(base + i) % N]) return (base + i) % N;
        end
        return -1;
    endfunction

    function automatic exp_t model_step(int d, bit r, logic [N-1:0] q, bit rl);
        exp_t e;
        bit   to_end;
        e.tmo      = 1'b0;
        e.idx_care = 1'b0;
        if (r) begin
            owner[d]    = -1;
            ptr[d]      = 0;
            held[d]     = 0;
            last_idx[d] = 0;
            e.idx_care  = 1'b1;
        end else if (owner[d] < 0) begin
            if (q != 0) begin
                owner[d]    = pick(ptr[d], q);
                held[d]     = 1;
                last_idx[d] = owner[d];
            end
        end else begin
            to_end = (hold_max[d] != 0) && (held[d] == hold_max[d]);
            if (rl || to_end) begin
                e.tmo  = to_end && !rl;
                ptr[d] = (owner[d] + 1) % N;
                if (q != 0) begin
                    owner[d]    = pick(ptr[d], q);
                    held[d]     = 1;
                    last_idx[d] = owner[d];
                end else begin
                    owner[d] = -1;
                end
            end else begin
                held[d]++;
            end
        end
        e.valid = (owner[d] >= 0);
        e.idx   = last_idx[d];
        if (e.valid) e.idx_care = 1'b1;
        return e;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare(string tag, exp_t e, logic v, logic [EW-1:0] ix, logic t, logic [N-1:0] sel);
        check({tag, " grant_valid"}, int'(v), int'(e.valid));
        check({tag, " timeout"}, int'(t), int'(e.tmo));
        if (e.idx_care) check({tag, " grant_idx"}, int'(ix), e.idx);
        if (e.valid) check({tag, " decoder_sel"}, int'(sel), 1 << e.idx);
    endtask

    task automatic drive(bit r, logic [N-1:0] q, bit rl);
        @(negedge clk);
        rst = r;
        req = q;
        rel = rl;
        sb0.push_back(model_step(0, r, q, rl));
        sb1.push_back(model_step(1, r, q, rl));
    endtask

    // Monitor: compares each registered output sample against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb0.size() > 0) begin
                e = sb0.pop_front();
                compare("dut0", e, v0, idx0, t0, sel0);
            end
            if (sb1.size() > 0) begin
                e = sb1.pop_front();
                compare("dut1", e, v1, idx1, t1, sel1);
            end
        end
    end

    initial begin
        rst = 1'b1;
        req = '0;
        rel = 1'b0;

        // Reset with all requesting, then first grant.
        drive(1, 4'b1111, 0);
        drive(1, 4'b1111, 0);
        drive(0, 4'b1111, 0);

        // Rotation with periodic release.
        for (int i = 0; i < 12; i++) drive(0, 4'b1111, (i % 3) == 2);

        // Wrap and fairness.
        drive(1, 4'b0000, 0);
        drive(0, 4'b1000, 0);
        drive(0, 4'b1000, 0);
        drive(0, 4'b1001, 1);
        drive(0, 4'b1001, 0);
        drive(0, 4'b1001, 1);
        drive(0, 4'b1001, 0);

        // Sole requester drops req while granted.
        drive(0, 4'b0000, 1);
        drive(0, 4'b0100, 0);
        for (int i = 0; i < 5; i++) drive(0, 4'b0000, 0);
        drive(0, 4'b0000, 1);
        drive(0, 4'b0000, 0);
        drive(0, 4'b0100, 0);
        drive(0, 4'b0100, 0);

        // Timeout, then release coinciding with timeout.
        drive(1, 4'b0000, 0);
        for (int i = 0; i < 12; i++) drive(0, 4'b0011, 0);
        drive(1, 4'b0000, 0);
        for (int i = 0; i < 4; i++) drive(0, 4'b0011, 0);
        drive(0, 4'b0011, 1);
        drive(0, 4'b0011, 0);

        // Reset mid-grant, then pointer restarts at 0.
        drive(1, 4'b0000, 0);
        drive(0, 4'b0100, 0);
        drive(0, 4'b0100, 0);
        drive(1, 4'b0100, 0);
        drive(0, 4'b0110, 0);
        drive(0, 4'b0110, 0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(99) == 0, N'($urandom), $urandom_range(3) == 0);
        end

        drive(0, 4'b0000, 0);
        @(posedge clk);
        #2;
        check("scoreboard0 drained", sb0.size(), 0);
        check("scoreboard1 drained", sb1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
